uart_tx_param: RTL and testbench

//  Parametrised UART transmitter. Successor to the fixed 8-bit TX top.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_param_if.sv | 31 +++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_tx_param.sv | 150 +++++++++++++++
 tb/tb_uart_tx_param.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
// States, parity encodings and the divider floor live here.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_typ_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/uart_tx_param_if.sv
// Word-in / serial-out bundle of the UART transmitter.
// master = bus write logic, slave = transmitter.
interface uart_tx_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
);

  logic [DATA_WIDTH-1:0] PAR_DATA;
  logic                  DATA_VALID;
  logic                  DATA_READY;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic [DIV_WIDTH-1:0]  BAUD_DIV;
  logic                  TX_OUT;
  logic                  BUSY;
  logic                  OVERRUN;

  modport master (
    output PAR_DATA, DATA_VALID,
    output PAR_EN, PAR_TYP, STOP2, BAUD_DIV,
    input  DATA_READY, TX_OUT, BUSY, OVERRUN
  );

  modport slave (
    input  PAR_DATA, DATA_VALID,
    input  PAR_EN, PAR_TYP, STOP2, BAUD_DIV,
    output DATA_READY, TX_OUT, BUSY, OVERRUN
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the UART transmitter.
// ready_o is registered so a same-cycle pop never frees a slot.
module uart_tx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          ready_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ready_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign ready_o = ready_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO, bit FSM, divider and parity.
// Config is captured per frame at pop time; frames run back-to-back.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input logic            CLK,
  input logic            RST,
  uart_tx_param_if.slave bus
);

  localparam int BW = $clog2(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  divl_q, divl_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  pen_q, pen_d;
  logic                  stp2_q, stp2_d;
  logic                  tx_q, tx_d;

  logic                  push, pop, empty, ready;
  logic                  tick, done, load;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DIV_WIDTH-1:0]  eff_div;

  assign push = bus.DATA_VALID & ready;

  uart_tx_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .wdata_i (bus.PAR_DATA),
    .pop_i   (pop),
    .rdata_o (rdata),
    .empty_o (empty),
    .ready_o (ready)
  );

  assign eff_div = (bus.BAUD_DIV < DIV_WIDTH'(MIN_DIV))
                 ? DIV_WIDTH'(MIN_DIV) : bus.BAUD_DIV;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    divl_d  = divl_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pen_d   = pen_q;
    stp2_d  = stp2_q;
    tx_d    = 1'b1;
    tick    = (div_q == '0);
    done    = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: load = ~empty;
      S_START: begin
        tx_d = 1'b0;
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_WIDTH-1))
            state_d = pen_q ? S_PARITY : S_STOP1;
          else
            bit_d = bit_q + BW'(1);
        end
      end
      S_PARITY: begin
        tx_d = par_q;
        if (tick) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (tick) begin
          if (stp2_q) state_d = S_STOP2;
          else        done    = 1'b1;
        end
      end
      S_STOP2: done = tick;
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE)
      div_d = tick ? divl_q - DIV_WIDTH'(1)
                   : div_q - DIV_WIDTH'(1);

    if (done) begin
      state_d = S_IDLE;
      load    = ~empty;
    end

    // Pop, latch config and parity together so mid-frame edits wait.
    if (load) begin
      pop     = 1'b1;
      state_d = S_START;
      shift_d = rdata;
      par_d   = (^rdata) ^ (bus.PAR_TYP == PAR_ODD);
      pen_d   = bus.PAR_EN;
      stp2_d  = bus.STOP2;
      divl_d  = eff_div;
      div_d   = eff_div - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      divl_q  <= DIV_WIDTH'(MIN_DIV);
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      stp2_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      divl_q  <= divl_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      stp2_q  <= stp2_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.TX_OUT     = tx_q;
  assign bus.DATA_READY = ready;
  assign bus.BUSY       = (state_q != S_IDLE) | ~empty;
  assign bus.OVERRUN    = bus.DATA_VALID & ~ready & ~RST;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frames, back-to-back, overrun,
// mid-frame reset and divider handling.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [31:0] cap;
  int          lat;
  bit          st;
  int          lows;
  logic [7:0]  wv [5];

  uart_tx_param_if #(.DATA_WIDTH(8), .DIV_WIDTH(16)) bus ();

  uart_tx_param #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .DIV_WIDTH  (16)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk(input logic [7:0] d,
                                     input bit pen,
                                     input bit ptyp,
                                     input bit st2);
    logic [31:0] f;
    f = '0;
    f = {f[30:0], 1'b0};
    for (int i = 0; i < 8; i++) f = {f[30:0], d[i]};
    if (pen) f = {f[30:0], (^d) ^ ptyp};
    f = {f[30:0], 1'b1};
    if (st2) f = {f[30:0], 1'b1};
    return f;
  endfunction

  task automatic push(input logic [7:0] d);
    @(posedge clk); #1;
    bus.DATA_VALID = 1'b1;
    bus.PAR_DATA   = d;
    @(posedge clk); #1;
    bus.DATA_VALID = 1'b0;
  endtask

  // First sample is the first negedge showing the start bit low;
  // every bit must hold for exactly div samples.
  task automatic rx_frame(input int div, input int nb,
                          output logic [31:0] c,
                          output int l, output bit s);
    logic v;
    c = '0;
    l = -1;
    s = 1'b1;
    v = 1'b1;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (bus.TX_OUT == 1'b0) begin
        l = w;
        break;
      end
    end
    if (l < 0) begin
      chk("rx start timeout", 32'd0, 32'd1);
      return;
    end
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < div; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        if (k == 0) v = bus.TX_OUT;
        else if (bus.TX_OUT !== v) s = 1'b0;
      end
      c = {c[30:0], v};
    end
  endtask

  task automatic count_low(input int n, output int lo);
    lo = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.TX_OUT !== 1'b1) lo++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
    bus.DATA_VALID = 1'b0;
    bus.PAR_DATA   = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.STOP2      = 1'b0;
    bus.BAUD_DIV   = 16'd4;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst tx", bus.TX_OUT, 1);
    chk("rst busy", bus.BUSY, 0);
    chk("rst ready", bus.DATA_READY, 0);
    chk("rst overrun", bus.OVERRUN, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready pre", bus.DATA_READY, 0);
    @(negedge clk);
    chk("ready post", bus.DATA_READY, 1);

    // 1: 0x1B odd parity, one stop
    bus.PAR_EN  = 1'b1;
    bus.PAR_TYP = 1'b1;
    push(8'h1B);
    chk("t1 busy rise", bus.BUSY, 1);
    rx_frame(4, 11, cap, lat, st);
    chk("t1 bits", cap, 32'b01101100011);
    chk("t1 latency", lat, 2);
    chk("t1 stable", st, 1);
    chk("t1 busy fall", bus.BUSY, 0);

    // 2: 0x1B odd then 0x69 even, no idle gap
    push(8'h1B);
    fork
      rx_frame(4, 22, cap, lat, st);
      begin
        repeat (12) @(posedge clk);
        #1 bus.PAR_TYP = 1'b0;
        push(8'h69);
      end
    join
    chk("t2 bits", cap, 32'b0110110001101001011001);
    chk("t2 stable", st, 1);
    chk("t2 busy", bus.BUSY, 0);

    // 3: 0x2D no parity, two stops
    bus.PAR_EN = 1'b0;
    bus.STOP2  = 1'b1;
    push(8'h2D);
    rx_frame(4, 11, cap, lat, st);
    chk("t3 bits", cap, 32'b01011010011);
    chk("t3 stable", st, 1);
    chk("t3 busy", bus.BUSY, 0);

    // 4: overrun on fifth word while a frame runs
    bus.STOP2 = 1'b0;
    push(8'h0F);
    fork
      rx_frame(4, 10, cap, lat, st);
      begin
        repeat (6) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          bus.DATA_VALID = 1'b1;
          bus.PAR_DATA   = wv[k];
          @(negedge clk);
          chk($sformatf("t4 ready%0d", k),
              bus.DATA_READY, (k < 4) ? 1 : 0);
          chk($sformatf("t4 ovr%0d", k),
              bus.OVERRUN, (k == 4) ? 1 : 0);
        end
        @(posedge clk); #1;
        bus.DATA_VALID = 1'b0;
        @(negedge clk);
        chk("t4 ovr pulse", bus.OVERRUN, 0);
      end
    join
    chk("t4 first", cap, mk(8'h0F, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      rx_frame(4, 10, cap, lat, st);
      chk($sformatf("t4 word%0d", k), cap, mk(wv[k], 0, 0, 0));
      chk($sformatf("t4 gap%0d", k), lat, 0);
      chk($sformatf("t4 stb%0d", k), st, 1);
    end
    chk("t4 busy", bus.BUSY, 0);
    count_low(60, lows);
    chk("t4 no fifth", lows, 0);

    // 5: reset during data bit 3 with two words queued
    push(8'hA5);
    push(8'h3C);
    push(8'hC3);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5 tx mid", bus.TX_OUT, 0);
    @(negedge clk);
    chk("t5 tx", bus.TX_OUT, 1);
    chk("t5 busy", bus.BUSY, 0);
    chk("t5 ready", bus.DATA_READY, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_low(100, lows);
    chk("t5 quiet", lows, 0);
    chk("t5 busy after", bus.BUSY, 0);
    chk("t5 ready after", bus.DATA_READY, 1);

    // 6: divider floor, then mid-frame divider change
    bus.BAUD_DIV = 16'd1;
    push(8'h3C);
    rx_frame(2, 10, cap, lat, st);
    chk("t6 div1 bits", cap, mk(8'h3C, 0, 0, 0));
    chk("t6 div1 lat", lat, 2);
    chk("t6 div1 stb", st, 1);
    bus.BAUD_DIV = 16'd4;
    push(8'hC3);
    fork
      rx_frame(4, 10, cap, lat, st);
      begin
        repeat (3) @(posedge clk);
        push(8'h5A);
        @(posedge clk); #1;
        bus.BAUD_DIV = 16'd8;
      end
    join
    chk("t6 f1 bits", cap, mk(8'hC3, 0, 0, 0));
    chk("t6 f1 stb", st, 1);
    rx_frame(8, 10, cap, lat, st);
    chk("t6 f2 bits", cap, mk(8'h5A, 0, 0, 0));
    chk("t6 f2 gap", lat, 0);
    chk("t6 f2 stb", st, 1);
    chk("t6 busy", bus.BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
